// File: rtl/iob_soc_opencryptolinux_spram_arb.sv
// rtl/iob_soc_opencryptolinux_spram_arb.sv - i/d port arbiter sharing one single-port byte-enable SRAM
// Optional feature macro: IOB_SOC_OPENCRYPTOLINUX_SPRAM_ARB_RR_EN
//   defined   -> round-robin on conflict (grant the port that did not win last)
//   undefined -> fixed priority, data port wins every conflict
module iob_soc_opencryptolinux_spram_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,
  input  logic                i_valid_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_wdata_i,
  input  logic [DATA_W/8-1:0] i_wstrb_i,
  output logic                i_ready_o,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  input  logic                d_valid_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic                d_ready_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                spram_en_o,
  output logic [ADDR_W-1:0]   spram_addr_o,
  output logic [DATA_W/8-1:0] spram_we_o,
  output logic [DATA_W-1:0]   spram_di_o,
  input  logic [DATA_W-1:0]   spram_do_i
);

  localparam int STRB_W = DATA_W / 8;

  // Port encoding for last_grant / rd_owner: 0 = instruction, 1 = data
  logic last_grant;
  logic rd_pend;
  logic rd_owner;

  logic gnt_i;
  logic gnt_d;
  logic pick_d;
  logic gnt_read;

  // Conflict resolution: which port wins when both request in the same slot
  always_comb begin
`ifdef IOB_SOC_OPENCRYPTOLINUX_SPRAM_ARB_RR_EN
    pick_d = ~last_grant;
`else
    // Data port always wins; last_grant is kept only for debug observation
    pick_d = last_grant | 1'b1;
`endif
  end

  // Grant: at most one port per slot, none while in reset or clock-disabled
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (rst_n_i && cke_i) begin
      if (i_valid_i && d_valid_i) begin
        gnt_d = pick_d;
        gnt_i = ~pick_d;
      end else begin
        gnt_i = i_valid_i;
        gnt_d = d_valid_i;
      end
    end
  end

  // RAM request mux; unused fields are driven 0 when nobody is granted
  always_comb begin
    spram_en_o   = 1'b0;
    spram_addr_o = '0;
    spram_we_o   = '0;
    spram_di_o   = '0;
    if (gnt_d) begin
      spram_en_o   = 1'b1;
      spram_addr_o = d_addr_i;
      spram_we_o   = d_wstrb_i;
      spram_di_o   = d_wdata_i;
    end else if (gnt_i) begin
      spram_en_o   = 1'b1;
      spram_addr_o = i_addr_i;
      spram_we_o   = i_wstrb_i;
      spram_di_o   = i_wdata_i;
    end
  end

  assign i_ready_o = gnt_i;
  assign d_ready_o = gnt_d;
  assign gnt_read  = spram_en_o && (spram_we_o == {STRB_W{1'b0}});

  // Read tracking and arbitration history; everything freezes while cke_i is low
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      last_grant <= 1'b1;
    end else if (cke_i) begin
      rd_pend <= gnt_read;
      if (gnt_read) begin
        rd_owner <= gnt_d;
      end
      if (spram_en_o) begin
        last_grant <= gnt_d;
      end
    end
  end

  // Return path: RAM output is steered to the port that issued the read
  always_comb begin
    i_rvalid_o = rst_n_i & rd_pend & ~rd_owner;
    d_rvalid_o = rst_n_i & rd_pend & rd_owner;
    i_rdata_o  = i_rvalid_o ? spram_do_i : '0;
    d_rdata_o  = d_rvalid_o ? spram_do_i : '0;
  end

endmodule

// File: tb/tb_iob_soc_opencryptolinux_spram_arb.sv
// tb/tb_iob_soc_opencryptolinux_spram_arb.sv - table-driven scoreboard bench for the spram arbiter
module tb_iob_soc_opencryptolinux_spram_arb;

`ifdef IOB_SOC_OPENCRYPTOLINUX_SPRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n, cke;
  logic        i_valid, d_valid;
  logic [15:0] i_addr, d_addr;
  logic [31:0] i_wdata, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;
  logic        i_ready, d_ready, i_rvalid, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        spram_en;
  logic [15:0] spram_addr;
  logic [3:0]  spram_we;
  logic [31:0] spram_di;
  logic [31:0] spram_do;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          rst_n;
    bit          cke;
    bit          iv;
    logic [15:0] ia;
    logic [3:0]  is;
    logic [31:0] iw;
    bit          dv;
    logic [15:0] da;
    logic [3:0]  ds;
    logic [31:0] dw;
    bit          exp_ir;
    bit          exp_dr;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];

  iob_soc_opencryptolinux_spram_arb #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke),
    .i_valid_i(i_valid), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
    .i_ready_o(i_ready), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_valid_i(d_valid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
    .d_ready_o(d_ready), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .spram_en_o(spram_en), .spram_addr_o(spram_addr), .spram_we_o(spram_we),
    .spram_di_o(spram_di), .spram_do_i(spram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port byte-enable RAM; output holds while en is low
  always @(posedge clk) begin
    if (spram_en) begin
      for (int b = 0; b < 4; b++)
        if (spram_we[b]) ram[spram_addr[7:0]][8*b +: 8] <= spram_di[8*b +: 8];
      if (spram_we == 4'h0) spram_do <= ram[spram_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit c, bit iv, logic [15:0] ia, logic [3:0] is, logic [31:0] iw,
                              bit dv, logic [15:0] da, logic [3:0] ds, logic [31:0] dw, bit eir, bit edr);
    vec_t v;
    v.rst_n = r; v.cke = c;
    v.iv = iv; v.ia = ia; v.is = is; v.iw = iw;
    v.dv = dv; v.da = da; v.ds = ds; v.dw = dw;
    v.exp_ir = eir; v.exp_dr = edr;
    return v;
  endfunction

  // One slot: drive, check at the falling edge, then advance the scoreboard/reference memory
  task automatic step(input vec_t v);
    logic [3:0]  exp_we;
    logic [15:0] exp_addr;
    logic [31:0] exp_di;
    bit          exp_iv, exp_dv;
    logic [31:0] exp_data;
    rst_n = v.rst_n; cke = v.cke;
    i_valid = v.iv; i_addr = v.ia; i_wstrb = v.is; i_wdata = v.iw;
    d_valid = v.dv; d_addr = v.da; d_wstrb = v.ds; d_wdata = v.dw;
    @(negedge clk);
    chk("i_ready", {31'd0, i_ready}, {31'd0, v.exp_ir});
    chk("d_ready", {31'd0, d_ready}, {31'd0, v.exp_dr});
    chk("spram_en", {31'd0, spram_en}, {31'd0, v.exp_ir | v.exp_dr});
    exp_we = v.exp_dr ? v.ds : (v.exp_ir ? v.is : 4'h0);
    chk("spram_we", {28'd0, spram_we}, {28'd0, exp_we});
    if (v.exp_ir || v.exp_dr) begin
      exp_addr = v.exp_dr ? v.da : v.ia;
      exp_di   = v.exp_dr ? v.dw : v.iw;
      chk("spram_addr", {16'd0, spram_addr}, {16'd0, exp_addr});
      chk("spram_di", spram_di, exp_di);
    end
    exp_iv = 1'b0; exp_dv = 1'b0; exp_data = 32'h0;
    if (v.rst_n && sb.size() > 0) begin
      exp_iv   = (sb[0].port == 1'b0);
      exp_dv   = (sb[0].port == 1'b1);
      exp_data = sb[0].data;
    end
    chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, exp_iv});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_dv});
    chk("i_rdata", i_rdata, exp_iv ? exp_data : 32'h0);
    chk("d_rdata", d_rdata, exp_dv ? exp_data : 32'h0);
    if (!v.rst_n) begin
      sb.delete();
    end else if (v.cke) begin
      if (sb.size() > 0) void'(sb.pop_front());
      if (v.exp_ir && v.is == 4'h0) sb.push_back('{port: 1'b0, data: ref_mem[v.ia[7:0]]});
      if (v.exp_dr && v.ds == 4'h0) sb.push_back('{port: 1'b1, data: ref_mem[v.da[7:0]]});
      for (int b = 0; b < 4; b++) begin
        if (v.exp_ir && v.is[b]) ref_mem[v.ia[7:0]][8*b +: 8] = v.iw[8*b +: 8];
        if (v.exp_dr && v.ds[b]) ref_mem[v.da[7:0]][8*b +: 8] = v.dw[8*b +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit eir;
    for (int a = 0; a < 256; a++) begin
      ram[a] = 32'h0;
      ref_mem[a] = 32'h0;
    end
    ram[1] = 32'h11; ref_mem[1] = 32'h11;
    ram[2] = 32'h22; ref_mem[2] = 32'h22;
    spram_do = 32'h0;
    rst_n = 1'b0; cke = 1'b1;
    i_valid = 1'b0; i_addr = '0; i_wdata = '0; i_wstrb = '0;
    d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;

    // reset with both valids high
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0));
    // continuous conflict reads: alternate under RR, data port always under fixed priority
    for (int k = 0; k < 6; k++) begin
      eir = RR && (k % 2 == 0);
      vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 2, 0, 0, eir, !eir));
    end
    // data port drops: the held instruction read goes through
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // single port write then read
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 4'hF, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 4'h0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // byte strobes, then reads from alternating ports, then read followed by write
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 7, 4'hF, 32'hAABBCCDD, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 7, 4'h1, 32'h000000EE, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 7, 4'h0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'hF, 32'h33, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // read granted, then clock enable low for 3 slots: no grants, rvalid held
    vecs.push_back(mk(1, 1, 1, 2, 4'h0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // read granted, then reset on the next edge: its rvalid is dropped
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2, 4'h0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    foreach (vecs[n]) step(vecs[n]);

    // no late rvalid ever appears after the reset-dropped read
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_rvalid_after_reset", {30'd0, i_rvalid, d_rvalid}, 32'h0);
      @(posedge clk);
      #1;
    end

    // merged byte-strobe result against its literal value
    step(mk(1, 1, 0, 0, 0, 0, 1, 7, 4'h0, 0, 0, 1));
    @(negedge clk);
    chk("byte_strobe_merge", d_rdata, 32'hAABBCCEE);
    chk("byte_strobe_i_quiet", {31'd0, i_rvalid}, 32'h0);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
